// File: rtl/ext_ram_arbiter.sv
// Round-robin arbiter with lock for the shared single-port 256x18 message RAM; routes read data back to the issuing port.
// Optional stall counters are enabled with EXT_RAM_ARB_STATS_EN.
module ext_ram_arbiter #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  output logic                  ram_cs,
  input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef EXT_RAM_ARB_STATS_EN
  ,
  output logic [15:0]           stall0_cnt,
  output logic [15:0]           stall1_cnt
`endif
);

  typedef enum logic [1:0] {ST_OPEN, ST_LOCK0, ST_LOCK1} state_t;

  state_t state_q, state_d;
  logic   rr_q, rr_d;
  logic   grant0, grant1;
  logic   rd_acc;

  logic [RD_LAT-1:0]     pv_q;
  logic [RD_LAT-1:0]     po_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  logic                  exit_v, exit_o;

  // Grants already include the requester's valid, so grantN means "accepted this cycle".
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_OPEN: begin
          if (req0_valid && req1_valid) begin
            grant0 = ~rr_q;
            grant1 = rr_q;
          end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
          end
        end
        ST_LOCK0: grant0 = req0_valid;
        ST_LOCK1: grant1 = req1_valid;
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (grant0) begin
      if (req0_lock) begin
        state_d = ST_LOCK0;
      end else begin
        state_d = ST_OPEN;
        rr_d    = 1'b1;
      end
    end else if (grant1) begin
      if (req1_lock) begin
        state_d = ST_LOCK1;
      end else begin
        state_d = ST_OPEN;
        rr_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OPEN;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    if (grant0) begin
      ram_cs      = 1'b1;
      ram_we      = req0_we;
      ram_address = req0_addr;
      ram_data_in = req0_wdata;
    end else if (grant1) begin
      ram_cs      = 1'b1;
      ram_we      = req1_we;
      ram_address = req1_addr;
      ram_data_in = req1_wdata;
    end
  end

  assign rd_acc = (grant0 && !req0_we) || (grant1 && !req1_we);

  // Tag pipeline matches the RAM read latency; its last stage lines up with ram_data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      po_q <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      po_q[0] <= grant1;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        po_q[i] <= po_q[i-1];
      end
    end
  end

  assign exit_v = pv_q[RD_LAT-1];
  assign exit_o = po_q[RD_LAT-1];

  assign rsp0_valid = !rst && exit_v && !exit_o;
  assign rsp1_valid = !rst && exit_v && exit_o;
  assign rsp0_rdata = rst ? '0 : (rsp0_valid ? ram_data_out : rdata0_q);
  assign rsp1_rdata = rst ? '0 : (rsp1_valid ? ram_data_out : rdata1_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rsp0_valid) rdata0_q <= ram_data_out;
      if (rsp1_valid) rdata1_q <= ram_data_out;
    end
  end

`ifdef EXT_RAM_ARB_STATS_EN
  logic [15:0] stall0_q, stall1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      if (req0_valid && !grant0 && stall0_q != 16'hFFFF) stall0_q <= stall0_q + 16'd1;
      if (req1_valid && !grant1 && stall1_q != 16'hFFFF) stall1_q <= stall1_q + 16'd1;
    end
  end

  assign stall0_cnt = stall0_q;
  assign stall1_cnt = stall1_q;
`endif

endmodule

// File: tb/tb_ext_ram_arbiter.sv
// Bench for ext_ram_arbiter: two instances (RD_LAT 1 and 3) share stimulus and are checked against a queue-based model.
module tb_ext_ram_arbiter;
  localparam int DW    = 18;
  localparam int AW    = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst, mem_clr;
  logic          req0_valid, req0_we, req0_lock, req1_valid, req1_we, req1_lock;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;

  logic          a_ready0, a_ready1, a_rsp0_valid, a_rsp1_valid, a_ram_we, a_ram_cs;
  logic [DW-1:0] a_rsp0_rdata, a_rsp1_rdata, a_ram_din, a_ram_dout;
  logic [AW-1:0] a_ram_addr;
  logic          b_ready0, b_ready1, b_rsp0_valid, b_rsp1_valid, b_ram_we, b_ram_cs;
  logic [DW-1:0] b_rsp0_rdata, b_rsp1_rdata, b_ram_din, b_ram_dout;
  logic [AW-1:0] b_ram_addr;
`ifdef EXT_RAM_ARB_STATS_EN
  logic [15:0] a_stall0, a_stall1, b_stall0, b_stall1;
`endif

  always #5 clk = ~clk;

  ext_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(a_ready0), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(a_ready1), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata),
    .ram_address(a_ram_addr), .ram_data_in(a_ram_din), .ram_we(a_ram_we), .ram_cs(a_ram_cs),
    .ram_data_out(a_ram_dout)
`ifdef EXT_RAM_ARB_STATS_EN
    , .stall0_cnt(a_stall0), .stall1_cnt(a_stall1)
`endif
  );

  ext_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(b_ready0), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(b_ready1), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .ram_address(b_ram_addr), .ram_data_in(b_ram_din), .ram_we(b_ram_we), .ram_cs(b_ram_cs),
    .ram_data_out(b_ram_dout)
`ifdef EXT_RAM_ARB_STATS_EN
    , .stall0_cnt(b_stall0), .stall1_cnt(b_stall1)
`endif
  );

  // Behavioural RAMs with 1-cycle and 3-cycle synchronous read.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] rp_a;
  logic [DW-1:0] rp_b [3];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= '0;
    end else begin
      if (a_ram_cs && a_ram_we) mem_a[a_ram_addr] <= a_ram_din;
      if (a_ram_cs && !a_ram_we) rp_a <= mem_a[a_ram_addr];
    end
  end
  assign a_ram_dout = rp_a;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= '0;
    end else begin
      if (b_ram_cs && b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
      if (b_ram_cs && !b_ram_we) rp_b[0] <= mem_b[b_ram_addr];
    end
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end
  assign b_ram_dout = rp_b[2];

  typedef struct {
    int          due;
    bit          own;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          qa[$];
  rsp_t          qb[$];
  int            cyc;
  int            m_lock;
  bit            m_rr;
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] hold_a [2];
  logic [DW-1:0] hold_b [2];
  logic [15:0]   st_m [2];
  int            nchk;
  int            nfail;

  logic          eg0, eg1, e_cs, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic          ev_a [2];
  logic          ev_b [2];
  logic [DW-1:0] ed_a [2];
  logic [DW-1:0] ed_b [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_dut(input string n, input logic r0, input logic r1, input logic cs, input logic we,
                         input logic [AW-1:0] ad, input logic [DW-1:0] di,
                         input logic v0, input logic [DW-1:0] d0, input logic v1, input logic [DW-1:0] d1,
                         input logic xv0, input logic [DW-1:0] xd0, input logic xv1, input logic [DW-1:0] xd1);
    chk({n, ".req0_ready"}, {31'd0, r0}, {31'd0, eg0});
    chk({n, ".req1_ready"}, {31'd0, r1}, {31'd0, eg1});
    chk({n, ".ram_cs"}, {31'd0, cs}, {31'd0, e_cs});
    chk({n, ".ram_we"}, {31'd0, we}, {31'd0, e_we});
    chk({n, ".ram_address"}, {24'd0, ad}, {24'd0, e_addr});
    chk({n, ".ram_data_in"}, {14'd0, di}, {14'd0, e_din});
    chk({n, ".rsp0_valid"}, {31'd0, v0}, {31'd0, xv0});
    chk({n, ".rsp0_rdata"}, {14'd0, d0}, {14'd0, xd0});
    chk({n, ".rsp1_valid"}, {31'd0, v1}, {31'd0, xv1});
    chk({n, ".rsp1_rdata"}, {14'd0, d1}, {14'd0, xd1});
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic tick();
    int            n;
    logic [AW-1:0] ad;
    @(negedge clk);
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      if (m_lock == 0)      eg0 = req0_valid;
      else if (m_lock == 1) eg1 = req1_valid;
      else if (req0_valid && req1_valid) begin
        eg0 = !m_rr;
        eg1 = m_rr;
      end else begin
        eg0 = req0_valid;
        eg1 = req1_valid;
      end
    end
    e_cs   = eg0 | eg1;
    e_we   = eg0 ? req0_we : (eg1 ? req1_we : 1'b0);
    e_addr = eg0 ? req0_addr : (eg1 ? req1_addr : '0);
    e_din  = eg0 ? req0_wdata : (eg1 ? req1_wdata : '0);
    for (int p = 0; p < 2; p++) begin
      ev_a[p] = !rst && qa.size() > 0 && qa[0].due == cyc && qa[0].own == p[0];
      ev_b[p] = !rst && qb.size() > 0 && qb[0].due == cyc && qb[0].own == p[0];
      ed_a[p] = rst ? '0 : (ev_a[p] ? qa[0].data : hold_a[p]);
      ed_b[p] = rst ? '0 : (ev_b[p] ? qb[0].data : hold_b[p]);
    end
    chk_dut("A", a_ready0, a_ready1, a_ram_cs, a_ram_we, a_ram_addr, a_ram_din,
            a_rsp0_valid, a_rsp0_rdata, a_rsp1_valid, a_rsp1_rdata, ev_a[0], ed_a[0], ev_a[1], ed_a[1]);
    chk_dut("B", b_ready0, b_ready1, b_ram_cs, b_ram_we, b_ram_addr, b_ram_din,
            b_rsp0_valid, b_rsp0_rdata, b_rsp1_valid, b_rsp1_rdata, ev_b[0], ed_b[0], ev_b[1], ed_b[1]);
`ifdef EXT_RAM_ARB_STATS_EN
    chk("A.stall0_cnt", {16'd0, a_stall0}, {16'd0, st_m[0]});
    chk("A.stall1_cnt", {16'd0, a_stall1}, {16'd0, st_m[1]});
    chk("B.stall0_cnt", {16'd0, b_stall0}, {16'd0, st_m[0]});
    chk("B.stall1_cnt", {16'd0, b_stall1}, {16'd0, st_m[1]});
`endif
    @(posedge clk);
    if (rst) begin
      m_lock = -1;
      m_rr   = 1'b0;
      qa.delete();
      qb.delete();
      for (int p = 0; p < 2; p++) begin
        hold_a[p] = '0;
        hold_b[p] = '0;
        st_m[p]   = '0;
      end
    end else begin
      if (req0_valid && !eg0 && st_m[0] != 16'hFFFF) st_m[0] = st_m[0] + 16'd1;
      if (req1_valid && !eg1 && st_m[1] != 16'hFFFF) st_m[1] = st_m[1] + 16'd1;
      if (ev_a[0] || ev_a[1]) begin
        hold_a[qa[0].own] = qa[0].data;
        void'(qa.pop_front());
      end
      if (ev_b[0] || ev_b[1]) begin
        hold_b[qb[0].own] = qb[0].data;
        void'(qb.pop_front());
      end
      if (eg0 || eg1) begin
        n  = eg1 ? 1 : 0;
        ad = e_addr;
        if (e_we) begin
          shadow[ad] = e_din;
        end else begin
          qa.push_back('{cyc + LAT_A, n[0], shadow[ad]});
          qb.push_back('{cyc + LAT_B, n[0], shadow[ad]});
        end
        if ((n == 0) ? req0_lock : req1_lock) begin
          m_lock = n;
        end else begin
          m_lock = -1;
          m_rr   = (n == 0);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    nchk = 0; nfail = 0; cyc = 0;
    m_lock = -1; m_rr = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    for (int p = 0; p < 2; p++) begin
      hold_a[p] = '0; hold_b[p] = '0; st_m[p] = '0;
    end
    rst = 1'b1; mem_clr = 1'b1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    mem_clr = 1'b0;

    // reset state
    repeat (2) tick();
    rst = 1'b0;

    // single write then read on port 0
    set0(1, 1, 0, 8'h10, 18'h2A5C3); tick();
    set0(1, 0, 0, 8'h10, 0);         tick();
    set0(0, 0, 0, 0, 0);
    repeat (4) tick();

    // round-robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    set0(1, 0, 0, 8'h10, 0);
    set1(1, 0, 0, 8'h05, 0);
    repeat (6) tick();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    repeat (4) tick();

    // port 1 read-modify-write under lock while port 0 waits
    set1(1, 0, 1, 8'h40, 0); tick();
    set1(0, 0, 0, 0, 0);
    set0(1, 0, 0, 8'h20, 0);
    repeat (9) tick();
    set1(1, 1, 0, 8'h40, 18'h155AA); tick();
    set1(0, 0, 0, 0, 0);
    repeat (2) tick();
    set0(0, 0, 0, 0, 0);
    repeat (4) tick();

    // reset while a read is in flight
    set0(1, 0, 0, 8'h10, 0); tick();
    set0(0, 0, 0, 0, 0);
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    repeat (5) tick();

    // back-to-back reads
    for (int i = 1; i <= 3; i++) begin
      set0(1, 1, 0, i[AW-1:0], i[DW-1:0]); tick();
    end
    for (int i = 1; i <= 3; i++) begin
      set0(1, 0, 0, i[AW-1:0], 0); tick();
    end
    set0(0, 0, 0, 0, 0);
    repeat (5) tick();

    // random traffic with occasional resets
    repeat (400) begin
      rst = ($urandom_range(0, 63) == 0);
      set0($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           AW'($urandom_range(0, 15)), DW'($urandom));
      set1($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           AW'($urandom_range(0, 15)), DW'($urandom));
      tick();
    end
    rst = 1'b0;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/ext_ram_arbiter.md
Name: ext_ram_arbiter

Overview:
- Shares the single-port 256x18 external message RAM between two requesters: port 0 is the channel-LLR loader, port 1 is the check-node update unit.
- Port 1 issues read-modify-write sequences, so the block provides a lock, and arbitration is round-robin.
- The block tracks the synchronous read latency and returns read data to the requester that issued the read, in issue order.
- It sits directly between the requesters and the RAM's address/data_in/we/cs/data_out pins.

Parameters:
- DATA_WIDTH, 18, RAM word width (three 6-bit lanes).
- ADDR_WIDTH, 8, RAM address width.
- RD_LAT, 1, cycles from accepted read to ram_data_out valid; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_we  input  1  1=write, 0=read.
- req0_lock  input  1  keep ownership after this transaction.
- req0_addr  input  ADDR_WIDTH  port 0 address.
- req0_wdata  input  DATA_WIDTH  port 0 write data.
- rsp0_valid  output  1  port 0 read data valid.
- rsp0_rdata  output  DATA_WIDTH  port 0 read data.
- req1_valid, req1_ready, req1_we, req1_lock, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_data_in  output  DATA_WIDTH  to RAM data_in.
- ram_we  output  1  to RAM we.
- ram_cs  output  1  to RAM cs.
- ram_data_out  input  DATA_WIDTH  from RAM data_out.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- A transaction is accepted on a cycle where reqN_valid and reqN_ready are both 1. At most one transaction is accepted per cycle, and back-to-back acceptance is allowed every cycle.
- RAM drive is combinational from the granted request:
  - With an accepted transaction: ram_cs=1, ram_we=reqN_we, ram_address=reqN_addr, ram_data_in=reqN_wdata.
  - With no accepted transaction: ram_cs=0, ram_we=0, and address/data hold 0.
- Ownership state machine:
  - States: OPEN and LOCK0/LOCK1.
  - OPEN: round-robin between valid requesters. Pointer rr resets to 0 and favours port rr. After each accepted transaction with lock=0, rr becomes the other port. With only one requester valid, that requester is granted regardless of rr.
  - OPEN->LOCKn: on an accepted transaction from port n with reqN_lock=1.
  - In LOCKn, only port n can get ready=1 (the other port is held at ready=0 even if port n is idle). LOCKn->OPEN on an accepted port n transaction with lock=0; rr then points to the other port.
- Read return:
  - A shift pipeline of depth RD_LAT carries {valid, owner} for every accepted read.
  - When the entry exits, rspN_valid=1 for exactly one cycle and rspN_rdata=ram_data_out.
  - Writes produce no response. The non-owner's rsp_valid stays 0 and its rdata holds its last value.
- Read-after-write to the same address on consecutive cycles returns the newly written data, provided by RAM ordering; there is no forwarding.
- Reset:
  - Values: req*_ready=0, rsp*_valid=0, rsp*_rdata=0, ram_cs=0, ram_we=0, state=OPEN, rr=0.
  - The in-flight read pipeline is cleared, so reads pending when rst is asserted mid-operation never return.
  - ready stays 0 while rst=1.
- Simultaneous events: with both ports valid in OPEN, grant port rr. A lock request and a competing request in the same cycle: the lock request wins only if its port holds the grant.

Optional Feature:
- Macro EXT_RAM_ARB_STATS_EN.
- When defined, adds outputs stall0_cnt and stall1_cnt (16 bits each). Each counts cycles where reqN_valid=1 and reqN_ready=0, saturating at 16'hFFFF, and is cleared by rst.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Single read: after rst, write port0 addr 8'h10 data 18'h2A5C3, then read addr 8'h10 -> rsp0_valid exactly RD_LAT cycles after read acceptance, rsp0_rdata=18'h2A5C3, rsp1_valid stays 0.
- Round-robin: both ports hold valid reads for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp owners match the issue order.
- Lock: port1 reads addr 8'h40 with lock=1 while port0 is valid -> req0_ready=0 until port1 writes 8'h40 with lock=0; port0 is granted the next cycle.
- Reset mid-flight: port0 read accepted, rst asserted the next cycle -> no rsp0_valid ever appears, and all outputs are 0 during rst.
- RD_LAT=3 back-to-back reads of addrs 1,2,3 holding 18'h00001, 18'h00002, 18'h00003 -> three consecutive rsp0_valid cycles starting 3 cycles after the first acceptance, data in order.
- With EXT_RAM_ARB_STATS_EN: port1 locked for 10 cycles while port0 is valid -> stall0_cnt=10, stall1_cnt=0.
